// File: rtl/mux16_pkg.sv
// Shared constants and state encoding for the 16:1 mux scan sequencer.
// Any block that needs the word/select geometry or the FSM states imports this package.
package mux16_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for a divide-by-div prescaler; a divide of 1 still needs one bit.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/mux16_step_timer.sv
// Step prescaler: divides the clock by STEP_DIV while enabled.
// step_tick marks the last cycle of each step; clear restarts the count at a new scan.
module mux16_step_timer
  import mux16_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic step_tick
);

  localparam int CNT_W = cnt_width(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign step_tick = en && (div_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == CNT_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux16_scan_ctrl.sv
// Scan sequencer for an external 16:1 bit-select mux: launches a word, steps the select
// 0..15, samples the mux output each step, reassembles it and flags whether it matches.
module mux16_scan_ctrl
  import mux16_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic [WIDTH-1:0] mux_in,
  output logic [SEL_W-1:0] mux_sel,
  input  logic             mux_out,
  output logic             bit_valid,
  output logic             bit_out,
  output logic [SEL_W-1:0] bit_idx,
  output logic             done,
  output logic [WIDTH-1:0] rx_word,
  output logic             match,
  output logic [1:0]       dbg_state
);

  // Handshake: a scan is accepted on a rising edge where start && ready; start while
  // ready=0 is dropped, not queued. bit_valid qualifies bit_out/bit_idx for that cycle only.

  state_t state, state_nxt;
  logic   start_acc;
  logic   step_tick;
  logic   last_step;

  assign start_acc = ready && start;
  assign bit_valid = (state == ST_SCAN) && step_tick;
  assign last_step = bit_valid && (mux_sel == SEL_LAST);
  assign bit_out   = mux_out;
  assign bit_idx   = mux_sel;
  assign dbg_state = state;

  mux16_step_timer #(
    .STEP_DIV (STEP_DIV)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_acc),
    .en        (state == ST_SCAN),
    .step_tick (step_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (last_step) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Select holds at 15 on the last step so it never wraps; it is parked at 0 in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_in  <= '0;
      mux_sel <= '0;
      rx_word <= '0;
      match   <= 1'b0;
    end else if (start_acc) begin
      mux_in  <= data_in;
      mux_sel <= '0;
      rx_word <= '0;
      match   <= 1'b0;
    end else if (bit_valid) begin
      rx_word[mux_sel] <= mux_out;
      if (mux_sel != SEL_LAST) begin
        mux_sel <= mux_sel + SEL_W'(1);
      end
    end else if (state == ST_DONE) begin
      match   <= (rx_word == mux_in);
      mux_sel <= '0;
    end
  end

  a_last_step_to_done : assert property (
    @(posedge clk) disable iff (!rst_n) last_step |=> (state == ST_DONE)
  );

  a_done_single : assert property (
    @(posedge clk) disable iff (!rst_n) done |=> !done
  );

endmodule
